// File: rtl/pcm_nrz_tx.sv
// PCM NRZ telemetry transmitter: byte FIFO feeding an MSB-first serializer
// that groups words into fixed-size frames, padding with 0x00 on underrun.
module pcm_nrz_tx #(
  parameter int CLK_HZ     = 10240000,
  parameter int BIT_RATE   = 51200,
  parameter int FRAME_SIZE = 128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  output logic       rx_ready,
  output logic       txd,
  output logic       frame_start,
  output logic       underrun,
  output logic       overflow,
  output logic       active
);

  localparam int CLK_DIV = CLK_HZ / BIT_RATE;
  localparam int TW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int WW      = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  localparam logic [TW-1:0] T_LAST   = TW'(CLK_DIV - 1);
  localparam logic [WW-1:0] W_LAST   = WW'(FRAME_SIZE - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_d;
  logic          fifo_empty, fifo_full, push, pop;

  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [WW-1:0] word_q, word_d;
  logic [7:0]    sh_q, sh_d;
  logic          fs_d, ur_d, fs_q, ur_q;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push       = rx_en && (!fifo_full || pop);
  assign count_d    = count + CW'(push) - CW'(pop);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    word_d  = word_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    fs_d    = 1'b0;
    ur_d    = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d  = '0;
        bit_d  = '0;
        word_d = '0;
        if (enable && !fifo_empty) begin
          state_d = RUN;
          pop     = 1'b1;
          sh_d    = mem[rd_ptr];
          fs_d    = 1'b1;
        end
      end
      RUN: begin
        if (tmr_q == T_LAST) begin
          tmr_d = '0;
          bit_d = bit_q + 3'd1;
          sh_d  = {sh_q[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            word_d = (word_q == W_LAST) ? '0 : word_q + 1'b1;
            // Enable is only honoured at a frame boundary; frames never truncate.
            if (word_q == W_LAST && !enable) begin
              state_d = IDLE;
            end else begin
              fs_d = (word_q == W_LAST);
              if (!fifo_empty) begin
                pop  = 1'b1;
                sh_d = mem[rd_ptr];
              end else begin
                sh_d = 8'h00;
                ur_d = 1'b1;
              end
            end
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      sh_q        <= '0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rx_ready    <= 1'b1;
      overflow    <= 1'b0;
      txd         <= 1'b0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      bit_q    <= bit_d;
      word_q   <= word_d;
      sh_q     <= sh_d;
      fs_q     <= fs_d;
      ur_q     <= ur_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_d;
      rx_ready <= (count_d != FULL_CNT);
      overflow <= rx_en && fifo_full && !pop;
      // Output stage: word pulses line up with the first cycle of its MSB on txd.
      txd         <= (state_q == RUN) && sh_q[7];
      active      <= (state_q == RUN);
      frame_start <= fs_q;
      underrun    <= ur_q;
    end
  end

endmodule
